// File: rtl/ttl_cpu_pkg.sv
// Shared encodings for the TTL CPU blocks: scan sequencer states and the
// 8-bit scan result layout.
package ttl_cpu;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } scan_state_e;

    localparam int unsigned DataW    = 8;
    localparam int unsigned CodeW    = 2;
    localparam int unsigned SettleW  = 4;
    localparam logic [CodeW-1:0] LastCode = 2'd3;

    // data[{half, code}]: y1 lands in the low nibble, y2 in the high nibble.
    localparam logic Y1Half = 1'b0;
    localparam logic Y2Half = 1'b1;

    localparam logic [DataW-1:0] DataClear = 8'h00;

endpackage

// File: rtl/settle_counter.sv
// 4-bit loadable down-counter with synchronous active-low clear; tc flags zero.
module settle_counter
    import ttl_cpu::*;
(
    input  logic               clk,
    input  logic               clr_n,
    input  logic               load,
    input  logic [SettleW-1:0] load_val,
    input  logic               dec,
    output logic [SettleW-1:0] count,
    output logic               tc
);

    logic [SettleW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps a dual 4-to-1 mux through codes 0..3, holding each SETTLE cycles, and
// assembles the two section outputs into one byte handed off with valid/ready.
module mux_scan_sequencer
    import ttl_cpu::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    output logic             busy,
    output logic             sel_a,
    output logic             sel_b,
    output logic             g1_n,
    output logic             g2_n,
    input  logic             y1,
    input  logic             y2,
    output logic [DataW-1:0] data,
    output logic             valid,
    input  logic             ready
);

    scan_state_e        state_q, state_d;
    logic [CodeW-1:0]   idx_q, idx_d;
    logic [DataW-1:0]   data_q, data_d;
    logic               cnt_load, cnt_dec, cnt_tc;
    logic [SettleW-1:0] cnt_value;

    // Reload value SETTLE-1 gives exactly SETTLE cycles per code before tc.
    settle_counter u_settle (
        .clk      (clk),
        .clr_n    (clr_n),
        .load     (cnt_load),
        .load_val (SettleW'(SETTLE - 1)),
        .dec      (cnt_dec),
        .count    (cnt_value),
        .tc       (cnt_tc)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        data_d   = data_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StScan;
                    idx_d    = '0;
                    data_d   = DataClear;
                    cnt_load = 1'b1;
                end
            end
            StScan: begin
                if (cnt_tc) begin
                    data_d[{Y1Half, idx_q}] = y1;
                    data_d[{Y2Half, idx_q}] = y2;
                    cnt_load = 1'b1;
                    if (idx_q == LastCode) begin
                        state_d = StDone;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StDone: begin
                if (ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            data_q  <= DataClear;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        busy  = (state_q != StIdle);
        valid = (state_q == StDone);
        g1_n  = (state_q != StScan);
        g2_n  = (state_q != StScan);
        sel_a = (state_q == StScan) ? idx_q[0] : 1'b0;
        sel_b = (state_q == StScan) ? idx_q[1] : 1'b0;
    end

    assign data = data_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench: one SETTLE=1 and one SETTLE=3 sequencer, each fed by a
// behavioural dual 4-to-1 mux model.
module tb_mux_scan_sequencer;

    logic clk = 1'b0;
    logic clr_n;
    logic start, ready;
    logic which;               // 0: SETTLE=1 instance, 1: SETTLE=3 instance
    int   y_mode;              // 0: pattern, 1: all ones, 2: all zeros
    logic y_tog;
    logic [3:0] pat1, pat2;

    logic       busy1, sa1, sb1, g11, g21, y11, y21, valid1;
    logic [7:0] data1;
    logic       busy3, sa3, sb3, g13, g23, y13, y23, valid3;
    logic [7:0] data3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    function automatic logic mux_out(input logic [3:0] pat, input logic [1:0] code, input int mode,
                                     input logic tog);
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'b0;
        return pat[code] ^ tog;
    endfunction

    assign y11 = mux_out(pat1, {sb1, sa1}, y_mode, y_tog);
    assign y21 = mux_out(pat2, {sb1, sa1}, y_mode, y_tog);
    assign y13 = mux_out(pat1, {sb3, sa3}, y_mode, y_tog);
    assign y23 = mux_out(pat2, {sb3, sa3}, y_mode, y_tog);

    mux_scan_sequencer #(.SETTLE(1)) u_dut1 (
        .clk(clk), .clr_n(clr_n), .start(start & ~which), .busy(busy1),
        .sel_a(sa1), .sel_b(sb1), .g1_n(g11), .g2_n(g21), .y1(y11), .y2(y21),
        .data(data1), .valid(valid1), .ready(ready & ~which)
    );

    mux_scan_sequencer #(.SETTLE(3)) u_dut3 (
        .clk(clk), .clr_n(clr_n), .start(start & which), .busy(busy3),
        .sel_a(sa3), .sel_b(sb3), .g1_n(g13), .g2_n(g23), .y1(y13), .y2(y23),
        .data(data3), .valid(valid3), .ready(ready & which)
    );

    logic       o_busy, o_valid, o_g1, o_g2;
    logic [1:0] o_sel;
    logic [7:0] o_data;
    assign o_busy  = which ? busy3 : busy1;
    assign o_valid = which ? valid3 : valid1;
    assign o_g1    = which ? g13 : g11;
    assign o_g2    = which ? g23 : g21;
    assign o_sel   = which ? {sb3, sa3} : {sb1, sa1};
    assign o_data  = which ? data3 : data1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Pulse (or hold) start and walk the scan cycle by cycle up to DONE.
    task automatic run_scan(input string tag, input int settle, input logic hold_start,
                            input logic [7:0] exp);
        start = 1'b1;
        step();
        if (!hold_start) start = 1'b0;
        check({tag, " busy"}, o_busy, 1);
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < settle; s++) begin
                check({tag, " sel"}, o_sel, k);
                check({tag, " g1_n"}, o_g1, 0);
                check({tag, " g2_n"}, o_g2, 0);
                check({tag, " valid early"}, o_valid, 0);
                step();
            end
        end
        check({tag, " valid"}, o_valid, 1);
        check({tag, " data"}, o_data, exp);
        check({tag, " done g1_n"}, o_g1, 1);
        check({tag, " done sel"}, o_sel, 0);
    endtask

    task automatic handshake(input string tag, input logic [7:0] exp);
        ready = 1'b1;
        step();
        ready = 1'b0;
        check({tag, " idle busy"}, o_busy, 0);
        check({tag, " idle valid"}, o_valid, 0);
        check({tag, " idle data"}, o_data, exp);
    endtask

    initial begin
        pat1 = 4'b1010;
        pat2 = 4'b0110;
        y_mode = 0; y_tog = 1'b0;
        which = 1'b0; start = 1'b0; ready = 1'b0; clr_n = 1'b0;
        step(); step();
        check("rst busy", o_busy, 0);
        check("rst valid", o_valid, 0);
        check("rst g1_n", o_g1, 1);
        check("rst g2_n", o_g2, 1);
        check("rst sel", o_sel, 0);
        check("rst data", o_data, 8'h00);
        clr_n = 1'b1;
        step();

        // Basic SETTLE=1 scan, then DONE stall with y wiggling.
        run_scan("s1", 1, 1'b0, 8'h6A);
        for (int i = 0; i < 5; i++) begin
            y_tog = ~y_tog;
            step();
            check("stall valid", o_valid, 1);
            check("stall data", o_data, 8'h6A);
        end
        y_tog = 1'b0;
        handshake("s1", 8'h6A);
        step();
        check("idle hold data", o_data, 8'h6A);
        check("idle stays", o_busy, 0);

        // start held through scan and handshake edge: one scan, then restart from IDLE.
        run_scan("hold", 1, 1'b1, 8'h6A);
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("hold hs busy", o_busy, 0);
        run_scan("hold2", 1, 1'b1, 8'h6A);
        start = 1'b0;
        handshake("hold2", 8'h6A);

        // Reset during code 2.
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        check("mid sel", o_sel, 2);
        clr_n = 1'b0;
        step();
        clr_n = 1'b1;
        check("mid busy", o_busy, 0);
        check("mid data", o_data, 8'h00);
        check("mid g1_n", o_g1, 1);
        check("mid g2_n", o_g2, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("mid no valid", o_valid, 0);
            check("mid no busy", o_busy, 0);
        end

        // Constant inputs.
        y_mode = 1;
        run_scan("ones", 1, 1'b0, 8'hFF);
        handshake("ones", 8'hFF);
        y_mode = 2;
        run_scan("zeros", 1, 1'b0, 8'h00);
        handshake("zeros", 8'h00);
        y_mode = 0;

        // SETTLE=3 with ready held high during the scan (ignored outside DONE).
        which = 1'b1;
        ready = 1'b1;
        run_scan("s3", 3, 1'b0, 8'h6A);
        step();
        ready = 1'b0;
        check("s3 idle busy", o_busy, 0);
        check("s3 idle data", o_data, 8'h6A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_sequencer.md
MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 SHALL have parameter SETTLE, default 1, range 1..15: cycles each select code is held before its sample is taken.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port clr_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1: request for one four-code scan.
REQ-005 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-006 SHALL have port sel_a, output, 1: A select to the dual 4-to-1 mux (LSB of the code).
REQ-007 SHALL have port sel_b, output, 1: B select to the dual 4-to-1 mux (MSB of the code).
REQ-008 SHALL have port g1_n, output, 1: mux section 1 enable, active-low.
REQ-009 SHALL have port g2_n, output, 1: mux section 2 enable, active-low.
REQ-010 SHALL have ports y1 and y2, input, 1 each: the mux section outputs.
REQ-011 SHALL have port data, output, 8: the scan result.
REQ-012 SHALL have port valid, output, 1: data holds a complete result.
REQ-013 SHALL have port ready, input, 1: consumer accepts the result.

Function
REQ-014 SHALL implement the states IDLE, SCAN and DONE.
REQ-015 In IDLE, SHALL drive g1_n=g2_n=1, sel_b/sel_a=00 and valid=0; data holds its last value.
REQ-016 On start=1 sampled in IDLE, SHALL enter SCAN with code idx=0 and clear data to 0x00.
REQ-017 In SCAN, SHALL drive g1_n=g2_n=0 and {sel_b,sel_a}=idx.
REQ-018 SHALL hold each idx for exactly SETTLE cycles, using a settle counter that reloads on every idx change.
REQ-019 On the edge that ends the SETTLE-th cycle of idx, SHALL write y1 into data[idx] and y2 into data[4+idx], then increment idx.
REQ-020 After the sample for idx=3, SHALL enter DONE; valid rises 4*SETTLE edges after the edge that accepted start.
REQ-021 In DONE, SHALL drive valid=1, g1_n=g2_n=1 and sel=00; data is stable until the handshake completes.
REQ-022 A handshake SHALL complete on an edge where valid=1 and ready=1; the next state is IDLE.
REQ-023 start SHALL be ignored in SCAN and DONE, including the edge that completes the handshake; start is not queued.
REQ-024 ready SHALL be ignored outside DONE.
REQ-025 Changes on y1/y2 outside the sampling edges SHALL NOT affect data.

Reset
REQ-026 clr_n=0 at a rising edge SHALL force IDLE, idx=0, settle counter=0, data=0x00, valid=0, busy=0, g1_n=g2_n=1 and sel=00, from any state including mid-SCAN.
REQ-027 A scan interrupted by reset SHALL NOT produce valid; a new start is required after clr_n returns high.

Structure
REQ-028 The state encoding (IDLE=0, SCAN=1, DONE=2) and the 8-bit data layout constants SHALL live in the shared ttl_cpu package.
REQ-029 The settle counter SHALL be one sub-module, settle_counter: a 4-bit loadable down-counter with a synchronous active-low clear and a terminal-count output.

Verification
REQ-030 SETTLE=1; y1 driven as the mux of 4'b1010 and y2 as the mux of 4'b0110 indexed by {sel_b,sel_a}; start pulsed -> codes 0,1,2,3 each held 1 cycle, valid rises 4 edges after start, data=0x6A.
REQ-031 SETTLE=3, same data pattern -> each code held exactly 3 cycles with enables low throughout, valid rises after 12 edges, data=0x6A.
REQ-032 In DONE, ready held 0 for 5 cycles and y toggled -> valid stays 1 and data is unchanged; ready=1 -> IDLE next edge with busy=0.
REQ-033 start held high through a whole scan and the handshake edge -> exactly one scan; a second scan begins only from IDLE.
REQ-034 clr_n pulsed low during code 2 of a scan -> next cycle IDLE, data=0x00, enables high, valid never asserted.
REQ-035 y1=y2=1 constant -> data=0xFF; y1=y2=0 constant -> data=0x00.
